// File: rtl/sd_scan_pkg.sv
// Shared types and helpers for the SD-card tag scanner: FSM states,
// sector size and ASCII letter classification.
package sd_scan_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    READ = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } scan_state_e;

  localparam int SECTOR_BYTES = 512;

  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_UC_Z = 8'h5A;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;

  function automatic logic is_letter(input logic [7:0] b);
    return ((b >= ASCII_UC_A) && (b <= ASCII_UC_Z)) ||
           ((b >= ASCII_LC_A) && (b <= ASCII_LC_Z));
  endfunction

endpackage

// File: rtl/sd_tag_word_counter_tag_matcher.sv
// Byte-serial tag detector: shifts in every enabled byte and flags, one cycle
// later, that the last TAG_LEN bytes spelled TAG.
module tag_matcher
  import sd_scan_pkg::*;
#(
  parameter int                   TAG_LEN = 8,
  parameter logic [8*TAG_LEN-1:0] TAG     = "DLAB_TAG"
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic       hit
);

  localparam int W = 8 * TAG_LEN;

  logic [W-1:0] r_shift;
  logic         r_hit;
  logic [W-1:0] w_shift_next;

  assign w_shift_next = {r_shift[W-9:0], din};

  // Shift register and registered compare; hit only pulses on the cycle after a new byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_hit   <= 1'b0;
    end else if (clr) begin
      r_shift <= '0;
      r_hit   <= 1'b0;
    end else if (en) begin
      r_shift <= w_shift_next;
      r_hit   <= (w_shift_next == TAG);
    end else begin
      r_hit   <= 1'b0;
    end
  end

  assign hit = r_hit;

endmodule

// File: rtl/sd_tag_word_counter.sv
// Streams sequential SD blocks, finds START_TAG..END_TAG and counts the words in
// between (all words, and those whose length equals word_len).
module sd_tag_word_counter
  import sd_scan_pkg::*;
#(
  parameter int                   TAG_LEN   = 8,
  parameter logic [8*TAG_LEN-1:0] START_TAG = "DLAB_TAG",
  parameter logic [8*TAG_LEN-1:0] END_TAG   = "DLAB_END",
  parameter int                   CNT_W     = 16,
  parameter int                   LEN_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      start_blk,
  input  logic [15:0]      max_blks,
  input  logic [LEN_W-1:0] word_len,
  input  logic             init_finished,
  output logic             rd_req,
  output logic [31:0]      rd_addr,
  input  logic [7:0]       sd_dout,
  input  logic             sd_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  localparam logic [9:0]       SECTOR_CNT = 10'(SECTOR_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W:0]   RUN_ONE    = {{LEN_W{1'b0}}, 1'b1};

  scan_state_e r_state;
  scan_state_e w_next;

  logic [31:0]      r_blk;
  logic [15:0]      r_left;
  logic [LEN_W-1:0] r_wlen;
  logic [9:0]       r_bcnt;
  logic             r_err;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_req;

  logic             r_inside;
  logic             r_started;
  logic             r_end_seen;

  logic [TAG_LEN-1:0][7:0] r_dl_data;
  logic [TAG_LEN-1:0]      r_dl_vld;
  logic [TAG_LEN-1:0]      w_dl_vld_next;

  logic [LEN_W:0]   r_run;
  logic [CNT_W-1:0] r_match;
  logic [CNT_W-1:0] r_total;

  logic       w_launch;
  logic       w_accept;
  logic       w_start_raw;
  logic       w_end_raw;
  logic       w_start_hit;
  logic       w_end_hit;
  logic       w_in_vld;
  logic [7:0] w_out_byte;
  logic       w_out_vld;
  logic       w_term;
  logic       w_grow;

  assign w_launch    = (r_state == IDLE) && start && init_finished;
  assign w_accept    = (r_state == READ) && sd_valid && (r_bcnt != SECTOR_CNT);
  assign w_start_hit = w_start_raw && !r_started;
  assign w_end_hit   = w_end_raw && r_inside;

  // Only bytes that arrive after the start tag (and before the end tag) are marked countable.
  assign w_in_vld   = w_start_hit || (r_inside && !w_end_hit);
  assign w_out_byte = r_dl_data[TAG_LEN-1];
  assign w_out_vld  = w_accept && r_dl_vld[TAG_LEN-1] && !w_start_hit && !w_end_hit;
  assign w_term     = w_end_hit || (w_out_vld && !is_letter(w_out_byte));
  assign w_grow     = w_out_vld && is_letter(w_out_byte);

  tag_matcher #(.TAG_LEN(TAG_LEN), .TAG(START_TAG)) u_start_match (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_launch),
    .en      (w_accept),
    .din     (sd_dout),
    .hit     (w_start_raw)
  );

  tag_matcher #(.TAG_LEN(TAG_LEN), .TAG(END_TAG)) u_end_match (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_launch),
    .en      (w_accept),
    .din     (sd_dout),
    .hit     (w_end_raw)
  );

  // Block-read sequencing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_launch) w_next = REQ;
        else          w_next = IDLE;
      end
      REQ:  w_next = READ;
      READ: begin
        if (r_bcnt == SECTOR_CNT) begin
          if (r_end_seen || w_end_hit) w_next = DONE;
          else                         w_next = NEXT;
        end else begin
          w_next = READ;
        end
      end
      NEXT: begin
        if (r_left == 16'd1) w_next = DONE;
        else                 w_next = REQ;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_req <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_busy   <= (w_next != IDLE);
      r_done   <= (w_next == DONE);
      r_rd_req <= (w_next == REQ);
    end
  end

  // Block address, remaining-block budget, sector byte count and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blk  <= 32'd0;
      r_left <= 16'd0;
      r_wlen <= '0;
      r_bcnt <= 10'd0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_blk  <= start_blk;
            r_left <= (max_blks == 16'd0) ? 16'd1 : max_blks;
            r_wlen <= word_len;
            r_err  <= 1'b0;
          end
        end
        REQ:  r_bcnt <= 10'd0;
        READ: begin
          if (w_accept) r_bcnt <= r_bcnt + 10'd1;
        end
        NEXT: begin
          r_blk  <= r_blk + 32'd1;
          r_left <= r_left - 16'd1;
          if (r_left == 16'd1) r_err <= 1'b1;
        end
        DONE: r_bcnt <= 10'd0;
        default: r_bcnt <= 10'd0;
      endcase
    end
  end

  // Tag region tracking: start is a one-shot per scan, end closes the region.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inside   <= 1'b0;
      r_started  <= 1'b0;
      r_end_seen <= 1'b0;
    end else if (w_launch) begin
      r_inside   <= 1'b0;
      r_started  <= 1'b0;
      r_end_seen <= 1'b0;
    end else begin
      if (w_start_hit) begin
        r_inside  <= 1'b1;
        r_started <= 1'b1;
      end
      if (w_end_hit) begin
        r_inside   <= 1'b0;
        r_end_seen <= 1'b1;
      end
    end
  end

  // A tag hit wipes every held byte, so tag characters never reach the word counter.
  always_comb begin
    w_dl_vld_next = r_dl_vld;
    if (w_launch) begin
      w_dl_vld_next = '0;
    end else if (w_accept) begin
      if (w_start_hit || w_end_hit) w_dl_vld_next = {{(TAG_LEN-1){1'b0}}, w_in_vld};
      else                          w_dl_vld_next = {r_dl_vld[TAG_LEN-2:0], w_in_vld};
    end else if (w_start_hit || w_end_hit) begin
      w_dl_vld_next = '0;
    end else begin
      w_dl_vld_next = r_dl_vld;
    end
  end

  // Delay-line storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_data <= '0;
      r_dl_vld  <= '0;
    end else begin
      r_dl_vld <= w_dl_vld_next;
      if (w_accept) r_dl_data <= {r_dl_data[TAG_LEN-2:0], sd_dout};
    end
  end

  // Run-length tracking and saturating word counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run   <= '0;
      r_match <= '0;
      r_total <= '0;
    end else if (w_launch) begin
      r_run   <= '0;
      r_match <= '0;
      r_total <= '0;
    end else if (w_term) begin
      if (r_run != '0) begin
        if (r_total != '1) r_total <= r_total + CNT_ONE;
        if ((r_run == {1'b0, r_wlen}) && (r_match != '1)) r_match <= r_match + CNT_ONE;
      end
      r_run <= '0;
    end else if (w_grow) begin
      if (r_run != '1) r_run <= r_run + RUN_ONE;
    end
  end

  assign rd_req    = r_rd_req;
  assign rd_addr   = r_blk;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign match_cnt = r_match;
  assign total_cnt = r_total;

endmodule

// File: tb/tb_sd_tag_word_counter.sv
// Scoreboard bench for sd_tag_word_counter with a behavioural sd_card byte source.
module tb_sd_tag_word_counter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_blk = 32'd0;
  logic [15:0] max_blks = 16'd0;
  logic [3:0]  word_len = 4'd0;
  logic        init_finished = 1'b0;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  sd_dout = 8'h00;
  logic        sd_valid = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] match_cnt;
  logic [15:0] total_cnt;

  always #5 clk = ~clk;

  sd_tag_word_counter #(
    .TAG_LEN(8), .START_TAG("DLAB_TAG"), .END_TAG("DLAB_END"), .CNT_W(16), .LEN_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_blk(start_blk),
    .max_blks(max_blks), .word_len(word_len), .init_finished(init_finished),
    .rd_req(rd_req), .rd_addr(rd_addr), .sd_dout(sd_dout), .sd_valid(sd_valid),
    .busy(busy), .done(done), .err(err), .match_cnt(match_cnt), .total_cnt(total_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Four-block disk image starting at disk_base; anything outside reads as space.
  logic [7:0]  disk [0:2047];
  logic [31:0] disk_base = 32'd0;

  function automatic logic [7:0] disk_byte(input logic [31:0] blk, input int idx);
    logic [31:0] rel;
    rel = blk - disk_base;
    if (rel < 32'd4) return disk[int'(rel) * 512 + idx];
    else             return 8'h20;
  endfunction

  task automatic load_disk(input logic [31:0] base);
    disk_base = base;
    for (int k = 0; k < 2048; k++) disk[k] = 8'h20;
  endtask

  task automatic put_text(input int off, input string s);
    for (int k = 0; k < s.len(); k++) disk[off + k] = s[k];
  endtask

  // sd_card model: records each request, then streams the sector with periodic idle gaps.
  int          rd_total = 0;
  logic [31:0] obs_addr [0:15];
  logic [31:0] m_addr;
  int          m_i;
  bit          m_gap;

  always begin
    @(negedge clk);
    if (reset_n && rd_req) begin
      obs_addr[rd_total % 16] = rd_addr;
      rd_total++;
      m_addr = rd_addr;
      m_i = 0;
      m_gap = 1'b0;
      while (m_i < 512) begin
        @(negedge clk);
        if (!reset_n) break;
        if (((m_i % 64) == 63) && !m_gap) begin
          sd_valid = 1'b0;
          m_gap = 1'b1;
        end else begin
          sd_dout = disk_byte(m_addr, m_i);
          sd_valid = 1'b1;
          m_i++;
          m_gap = 1'b0;
        end
      end
      if (reset_n) @(negedge clk);
      sd_valid = 1'b0;
    end
  end

  typedef struct {
    int m;
    int t;
    int e;
    int b;
  } exp_t;

  exp_t exp_q[$];

  task automatic run_scan(input string name, input logic [31:0] sb, input logic [15:0] mb,
                          input logic [3:0] wl, input int em, input int et, input int ee,
                          input int eb, input bit poke);
    exp_t ex;
    int   snap;
    int   seen;
    int   cyc;
    exp_q.push_back('{m: em, t: et, e: ee, b: eb});
    snap = rd_total;
    @(negedge clk);
    start_blk = sb; max_blks = mb; word_len = wl; start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_blk = 32'hDEAD_0000; word_len = 4'd1;
    check_eq({name, "_rdreq_hi"}, 32'(rd_req), 32'd1);
    check_eq({name, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check_eq({name, "_rdreq_lo"}, 32'(rd_req), 32'd0);
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (!done && (cyc < 20000)) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({name, "_done_seen"}, 32'(done), 32'd1);
    ex = exp_q.pop_front();
    seen = rd_total - snap;
    check_eq({name, "_match"}, 32'(match_cnt), 32'(ex.m));
    check_eq({name, "_total"}, 32'(total_cnt), 32'(ex.t));
    check_eq({name, "_err"}, 32'(err), 32'(ex.e));
    check_eq({name, "_blocks"}, 32'(seen), 32'(ex.b));
    for (int k = 0; k < ex.b; k++)
      if (k < seen) check_eq({name, "_addr"}, obs_addr[(snap + k) % 16], sb + 32'(k));
    @(negedge clk);
    check_eq({name, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    check_eq("rst_rdreq", 32'(rd_req), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_match", 32'(match_cnt), 32'd0);
    check_eq("rst_total", 32'(total_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    init_finished = 1'b1;

    load_disk(32'h100);
    put_text(0, "xx DLAB_TAG the cat ran DLAB_END");
    run_scan("basic", 32'h100, 16'd4, 4'd3, 3, 3, 0, 1, 1'b0);
    run_scan("wlen0", 32'h100, 16'd1, 4'd0, 0, 3, 0, 1, 1'b0);

    load_disk(32'h2000);
    put_text(508, "DLAB");
    put_text(512, "_TAG a bb ccc DLAB_END");
    run_scan("straddle", 32'h2000, 16'd3, 4'd2, 1, 3, 0, 2, 1'b0);

    load_disk(32'h200);
    put_text(0, "DLAB_TAGcatDLAB_END");
    run_scan("adjacent", 32'h200, 16'd2, 4'd3, 1, 1, 0, 1, 1'b0);

    load_disk(32'h300);
    put_text(5, "DLAB_TAG one two ");
    run_scan("noend", 32'h300, 16'd4, 4'd3, 2, 2, 1, 4, 1'b0);
    run_scan("maxblk0", 32'h300, 16'd0, 4'd3, 2, 2, 1, 1, 1'b0);

    load_disk(32'h500);
    put_text(0, "DLAB_TAG abcdefghijklmnopqrst DLAB_END");
    run_scan("longrun", 32'h500, 16'd2, 4'd15, 0, 1, 0, 1, 1'b1);

    load_disk(32'h600);
    put_text(0, "DLAB_TAG abcdefghijklmno xy DLAB_END");
    run_scan("len15", 32'h600, 16'd2, 4'd15, 1, 2, 0, 1, 1'b0);

    load_disk(32'h400);
    put_text(0, "DLAB_TAG ab ");
    put_text(504, "DLAB_END");
    run_scan("edge512", 32'h400, 16'd1, 4'd2, 1, 1, 0, 1, 1'b0);

    // Reset in the middle of a sector read, then a scan gated by init_finished.
    load_disk(32'h100);
    put_text(0, "xx DLAB_TAG the cat ran DLAB_END");
    @(negedge clk);
    start_blk = 32'h100; max_blks = 16'd1; word_len = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("mid_match", 32'(match_cnt), 32'd3);
    check_eq("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    init_finished = 1'b0;
    #1;
    check_eq("arst_rdreq", 32'(rd_req), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_err", 32'(err), 32'd0);
    check_eq("arst_match", 32'(match_cnt), 32'd0);
    check_eq("arst_total", 32'(total_cnt), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("noinit_rdreq", 32'(rd_req), 32'd0);
    check_eq("noinit_busy", 32'(busy), 32'd0);
    init_finished = 1'b1;
    run_scan("after_rst", 32'h100, 16'd1, 4'd3, 3, 3, 0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
